rr_mux_n: RTL

Parametrised registered N-to-1 multiplexer with round-robin arbitration and valid/ready handshaking. It generalises the team's 4:1 combinational mux to NCH channels of WIDTH bits. One output register stage is placed between arbitration and the consumer. It is used wherever several producers share one downstream datapath, for example bus or writeback sharing.

---
 rtl/rr_mux_pkg.sv | 19 +
 rtl/rr_pick.sv | 40 ++++
 rtl/rr_mux_n.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin registered mux (rr_mux_n).
package rr_mux_pkg;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    // Ceiling log2 used to size channel-index fields.
    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or above ptr, modulo NCH.
module rr_pick
    import rr_mux_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int SELW = (NCH <= 1) ? 1 : clog2_f(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [NCH-1:0]  gnt_onehot,
    output logic [SELW-1:0] gnt_idx,
    output logic            any_req
);

    int w_dist;
    int w_best;

    // Lowest rotational distance from ptr wins; wrap is at NCH, not 2^SELW.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any_req    = 1'b0;
        w_best     = NCH;
        w_dist     = 0;
        for (int i = 0; i < NCH; i++) begin
            w_dist = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + NCH - int'(ptr));
            if (req[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                gnt_idx = SELW'(i);
                any_req = 1'b1;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (any_req && (int'(gnt_idx) == i)) begin
                gnt_onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_n.sv
// Registered N-to-1 round-robin mux with valid/ready handshake.
// Optional burst lock enabled by defining RR_MUX_LOCK_EN.
module rr_mux_n
    import rr_mux_pkg::*;
#(
    parameter int   WIDTH = 4,
    parameter int   NCH   = 4,
    localparam int  SELW  = (NCH <= 1) ? 1 : clog2_f(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
`ifdef RR_MUX_LOCK_EN
    input  logic [NCH-1:0]       in_last,
`endif
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_sel;
    logic [SELW-1:0]  r_ptr;

    logic             w_ld;
    logic             w_any;
    logic             w_ok;
    logic             w_xfer;
    logic             w_last;
    logic [NCH-1:0]   w_gnt_oh;
    logic [SELW-1:0]  w_gnt_idx;
    logic [SELW-1:0]  w_pick_ptr;
    logic [SELW-1:0]  w_ptr_nxt;
    logic [WIDTH-1:0] w_data;

`ifdef RR_MUX_LOCK_EN
    state_e          r_state;
    logic [SELW-1:0] r_lock_ch;

    // While locked the picker starts at lock_ch; any other winner is refused.
    assign w_pick_ptr = (r_state == ST_LOCK) ? r_lock_ch : r_ptr;
    assign w_ok       = (r_state == ST_ARB) || (w_gnt_idx == r_lock_ch);
`else
    assign w_pick_ptr = r_ptr;
    assign w_ok       = 1'b1;
`endif

    rr_pick #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_pick (
        .req        (in_valid),
        .ptr        (w_pick_ptr),
        .gnt_onehot (w_gnt_oh),
        .gnt_idx    (w_gnt_idx),
        .any_req    (w_any)
    );

    always_comb begin
        w_data = '0;
        w_last = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (w_gnt_oh[i]) begin
                w_data = in_data[i*WIDTH +: WIDTH];
`ifdef RR_MUX_LOCK_EN
                w_last = in_last[i];
`endif
            end
        end
    end

    assign w_ld      = !r_out_valid || out_ready;
    assign w_xfer    = rst_n && w_ld && w_any && w_ok;
    assign in_ready  = w_xfer ? w_gnt_oh : '0;
    assign w_ptr_nxt = (int'(w_gnt_idx) == NCH - 1) ? '0 : (w_gnt_idx + 1'b1);

    // Output register; ptr only moves on the closing beat of a burst.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else if (w_ld) begin
            r_out_valid <= w_xfer;
            if (w_xfer) begin
                r_out_data <= w_data;
                r_out_sel  <= w_gnt_idx;
                if (w_last) begin
                    r_ptr <= w_ptr_nxt;
                end
            end
        end
    end

`ifdef RR_MUX_LOCK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_ARB;
            r_lock_ch <= '0;
        end else if (w_xfer) begin
            case (r_state)
                ST_ARB: begin
                    if (!w_last) begin
                        r_state   <= ST_LOCK;
                        r_lock_ch <= w_gnt_idx;
                    end
                end
                ST_LOCK: begin
                    if (w_last) begin
                        r_state <= ST_ARB;
                    end
                end
                default: r_state <= ST_ARB;
            endcase
        end
    end
`endif

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule
